// File: rtl/lathe_seq_pkg.sv
// State encodings and drive-output decode for the lathe cycle sequencer.
// Shared by the sequencer top and its bench-facing state output.
package lathe_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SPINUP   = 3'd1,
        ST_FEED     = 3'd2,
        ST_DWELL    = 3'd3,
        ST_RETRACT  = 3'd4,
        ST_SPINDOWN = 3'd5,
        ST_FAULT    = 3'd6,
        ST_MANUAL   = 3'd7
    } state_t;

    typedef struct packed {
        logic spindle_on;
        logic coolant_on;
        logic feed_fwd;
        logic feed_rev;
    } drive_t;

    localparam drive_t DRV_OFF       = 4'b0000;
    localparam drive_t DRV_SPIN      = 4'b1000;
    localparam drive_t DRV_SPIN_COOL = 4'b1100;
    localparam drive_t DRV_FEED      = 4'b1110;
    localparam drive_t DRV_RETRACT   = 4'b1001;

    function automatic drive_t decode_drive(input state_t s);
        drive_t d;
        case (s)
            ST_SPINUP:  d = DRV_SPIN_COOL;
            ST_FEED:    d = DRV_FEED;
            ST_DWELL:   d = DRV_SPIN_COOL;
            ST_RETRACT: d = DRV_RETRACT;
            ST_MANUAL:  d = DRV_SPIN;
            default:    d = DRV_OFF;
        endcase
        return d;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lathe_phase_timer.sv
// Phase timer: counts enabled cycles since the last clear, saturating at all-ones.
// tc flags count == limit; the limit is supplied at run time by the owning FSM.
module lathe_phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         tc
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == limit);

endmodule

// File: rtl/lathe_cycle_sequencer.sv
// Turning-pass sequencer: spin-up, feed, dwell, retract, spin-down, plus manual jog and latched fault.
// Define LATHE_WATCHDOG_EN to fault FEED/RETRACT that run FEED_TIMEOUT cycles without their exit limit.
module lathe_cycle_sequencer
    import lathe_seq_pkg::*;
#(
    parameter int unsigned SPINUP_TICKS   = 150_000_000,
    parameter int unsigned DWELL_TICKS    = 50_000_000,
    parameter int unsigned SPINDOWN_TICKS = 100_000_000,
    parameter int unsigned FEED_TIMEOUT   = 500_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       estop,
    input  logic       fault_clr,
    input  logic       auto_mode,
    input  logic       man_mode,
    input  logic       limit_home,
    input  logic       limit_end,
    output logic       spindle_on,
    output logic       coolant_on,
    output logic       feed_fwd,
    output logic       feed_rev,
    output logic       busy,
    output logic       fault,
    output logic [2:0] state
);

    localparam int unsigned MAX_TICKS = max_u(max_u(SPINUP_TICKS, DWELL_TICKS),
                                              max_u(SPINDOWN_TICKS, FEED_TIMEOUT));
    localparam int CW = $clog2(MAX_TICKS) + 1;

    localparam logic [CW-1:0] LIM_SPINUP   = CW'(SPINUP_TICKS - 1);
    localparam logic [CW-1:0] LIM_DWELL    = CW'(DWELL_TICKS - 1);
    localparam logic [CW-1:0] LIM_SPINDOWN = CW'(SPINDOWN_TICKS - 1);
    localparam logic [CW-1:0] LIM_TIMEOUT  = CW'(FEED_TIMEOUT - 1);

    state_t        state_q;
    state_t        next_state;
    logic          start_q;
    logic          start_rise;
    logic          limit_conflict;
    logic          mode_conflict;
    logic          running;
    logic          timer_en;
    logic          timer_clr;
    logic          phase_tc;
    logic [CW-1:0] phase_limit;
    logic [CW-1:0] phase_count;
    drive_t        next_drive;

    assign start_rise     = start & ~start_q;
    assign limit_conflict = limit_home & limit_end;
    assign mode_conflict  = auto_mode & man_mode;
    assign running        = (state_q == ST_SPINUP) || (state_q == ST_FEED) ||
                            (state_q == ST_DWELL) || (state_q == ST_RETRACT) ||
                            (state_q == ST_MANUAL);

    always_comb begin
        timer_en    = 1'b0;
        phase_limit = LIM_TIMEOUT;
        case (state_q)
            ST_SPINUP: begin
                timer_en    = 1'b1;
                phase_limit = LIM_SPINUP;
            end
            ST_DWELL: begin
                timer_en    = 1'b1;
                phase_limit = LIM_DWELL;
            end
            ST_SPINDOWN: begin
                timer_en    = 1'b1;
                phase_limit = LIM_SPINDOWN;
            end
`ifdef LATHE_WATCHDOG_EN
            ST_FEED, ST_RETRACT: timer_en = 1'b1;
`endif
            default: ;
        endcase
    end

    assign timer_clr = (next_state != state_q);

    lathe_phase_timer #(
        .W(CW)
    ) u_phase_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (timer_clr),
        .en    (timer_en),
        .limit (phase_limit),
        .count (phase_count),
        .tc    (phase_tc)
    );

    always_comb begin
        next_state = state_q;
        if (estop || limit_conflict || mode_conflict) begin
            next_state = ST_FAULT;
        end else if (stop && running) begin
            next_state = ST_SPINDOWN;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // An AUTO rise away from home is deliberately dropped, not held over.
                    if (auto_mode && start_rise && limit_home) begin
                        next_state = ST_SPINUP;
                    end else if (man_mode && start_rise) begin
                        next_state = ST_MANUAL;
                    end
                end
                ST_SPINUP: if (phase_tc) next_state = ST_FEED;
                ST_FEED: begin
                    if (limit_end) begin
                        next_state = ST_DWELL;
`ifdef LATHE_WATCHDOG_EN
                    end else if (phase_tc) begin
                        next_state = ST_FAULT;
`endif
                    end
                end
                ST_DWELL: if (phase_tc) next_state = ST_RETRACT;
                ST_RETRACT: begin
                    if (limit_home) begin
                        next_state = ST_SPINDOWN;
`ifdef LATHE_WATCHDOG_EN
                    end else if (phase_tc) begin
                        next_state = ST_FAULT;
`endif
                    end
                end
                ST_MANUAL: if (!start || !man_mode) next_state = ST_SPINDOWN;
                ST_SPINDOWN: if (phase_tc) next_state = ST_IDLE;
                // estop and both conflicts are already excluded by the priority above.
                ST_FAULT: if (fault_clr && !start) next_state = ST_IDLE;
                default: next_state = ST_FAULT;
            endcase
        end
    end

    assign next_drive = decode_drive(next_state);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            start_q    <= 1'b0;
            spindle_on <= 1'b0;
            coolant_on <= 1'b0;
            feed_fwd   <= 1'b0;
            feed_rev   <= 1'b0;
            busy       <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state_q    <= next_state;
            start_q    <= start;
            spindle_on <= next_drive.spindle_on;
            coolant_on <= next_drive.coolant_on;
            feed_fwd   <= next_drive.feed_fwd;
            feed_rev   <= next_drive.feed_rev;
            busy       <= (next_state != ST_IDLE) && (next_state != ST_FAULT);
            fault      <= (next_state == ST_FAULT);
        end
    end

    assign state = state_q;

    phase_in_range: assert property (@(posedge clk) disable iff (reset)
        timer_en |-> (phase_count <= phase_limit));

endmodule

// File: doc/lathe_cycle_sequencer.md
# lathe_cycle_sequencer

Sequences one automatic turning pass on the retrofitted manual lathe: spindle spin-up, feed to end-of-travel, dwell, retract to home, spin-down. It also provides a manual jog mode, stop and e-stop handling, and a latched fault state. It sits between the operator panel / limit-switch inputs and the spindle, coolant and feed drive outputs. It is the sequencer above the simple start/AUTO/MAN timer control.

## Interface
- `SPINUP_TICKS`, 150_000_000: cycles in SPINUP (3 s at 50 MHz); minimum 1.
- `DWELL_TICKS`, 50_000_000: cycles in DWELL; minimum 1.
- `SPINDOWN_TICKS`, 100_000_000: cycles in SPINDOWN; minimum 1.
- `FEED_TIMEOUT`, 500_000_000: watchdog limit for FEED and RETRACT (only with `LATHE_WATCHDOG_EN`).
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  operator start, level.
- `stop`  in  1  operator stop, level.
- `estop`  in  1  emergency stop, level.
- `fault_clr`  in  1  fault acknowledge, level.
- `auto_mode`  in  1  AUTO selector.
- `man_mode`  in  1  MAN selector.
- `limit_home`  in  1  carriage at home.
- `limit_end`  in  1  carriage at end of travel.
- `spindle_on`  out  1  spindle contactor.
- `coolant_on`  out  1  coolant pump.
- `feed_fwd`  out  1  feed toward end.
- `feed_rev`  out  1  feed toward home.
- `busy`  out  1  state is not IDLE and not FAULT.
- `fault`  out  1  state is FAULT.
- `state`  out  3  current state encoding.

All inputs are already synchronised upstream.

## Operation
States, with encoding and asserted outputs:
- IDLE = 0: no outputs.
- SPINUP = 1: spindle, coolant.
- FEED = 2: spindle, coolant, feed_fwd.
- DWELL = 3: spindle, coolant.
- RETRACT = 4: spindle, feed_rev.
- SPINDOWN = 5: no outputs.
- FAULT = 6: fault only.
- MANUAL = 7: spindle.

Start detection:
- `start_rise` = `start` & !`start_q`.
- `start_q` is a register, reset to 0.

Transitions are evaluated in priority order, highest first:
1. `estop`, or `limit_home` & `limit_end`, or `auto_mode` & `man_mode`: any state goes to FAULT.
2. `stop` while SPINUP, FEED, DWELL, RETRACT or MANUAL: go to SPINDOWN.
3. IDLE:
   - `auto_mode` & `start_rise` & `limit_home`: go to SPINUP.
   - `man_mode` & `start_rise`: go to MANUAL.
   - A rise while `auto_mode` is set but `limit_home` is low is ignored.
4. SPINUP: go to FEED at terminal count.
5. FEED: go to DWELL when `limit_end` is high.
6. DWELL: go to RETRACT at terminal count.
7. RETRACT: go to SPINDOWN when `limit_home` is high.
8. MANUAL: go to SPINDOWN when `start` or `man_mode` is low.
9. SPINDOWN: go to IDLE at terminal count.
10. FAULT: go to IDLE when `fault_clr` & !`estop` & !`start` & no limit conflict & no mode conflict.

Phase timer:
- Clears to 0 on every state change.
- Otherwise increments in timed states.
- Terminal count is `count == TICKS-1`, so the state lasts exactly TICKS cycles.
- Counter width is `$clog2` of the largest parameter, plus 1.
- Counter saturates and never wraps.

Holding `start` does not retrigger a cycle; a new rising edge is required.

## Timing
- Reset value:
  - All outputs 0 and `state` = IDLE.
  - Counter 0 and `start_q` 0.
- Outputs are registered and decoded from next-state, so outputs change on the same edge as `state`; added latency is zero.
- `start_rise` sampled high at edge N: `spindle_on` is 1 after edge N.
- FEED is entered at edge N + `SPINUP_TICKS`.
- `estop` sampled at edge N: all drive outputs are 0 after edge N.
- `limit_end` in FEED at edge N: `feed_fwd` is 0 and state is DWELL after edge N.
- Simultaneous `stop` and `estop`: FAULT wins.
- Simultaneous `start_rise` and `stop` in IDLE: SPINUP is entered. `stop` is only acted on in running states.
- Reset asserted mid-cycle: asynchronous return to the reset values.

## Configuration
- `LATHE_WATCHDOG_EN` defined:
  - The counter also runs in FEED and RETRACT.
  - Reaching `FEED_TIMEOUT`-1 without the exit limit goes to FAULT.
  - The limit arriving on the timeout edge wins.
- `LATHE_WATCHDOG_EN` undefined:
  - The counter holds 0 in FEED and RETRACT.
  - There is no timeout, and `FEED_TIMEOUT` is unused.

## Structure
- Package `lathe_seq_pkg` holds:
  - The state enum and its 3-bit encodings.
  - The output-decode constants.
- Sub-module `lathe_phase_timer` provides:
  - Parameterised width.
  - Inputs `clr` and `en`; outputs `count` and `tc` against a runtime limit.

## Test plan
Bench parameters: `SPINUP_TICKS`=20, `DWELL_TICKS`=10, `SPINDOWN_TICKS`=5, `FEED_TIMEOUT`=50.
1. Reset pulse with random inputs -> all outputs 0, `state`=0, `busy`=0.
2. `limit_home`=1, `auto_mode`=1, `start` pulse:
   - -> `spindle_on` and `coolant_on` next edge.
   - -> `feed_fwd` after 20 cycles.
   - `limit_end` raised -> DWELL for 10 cycles, then `feed_rev`.
   - `limit_home` raised -> SPINDOWN for 5 cycles, then IDLE.
   - `start` held throughout -> no second cycle.
3. `man_mode`=1, `start` held 8 cycles:
   - -> `spindle_on` for those cycles, `feed_*` stay 0.
   - `start` released -> SPINDOWN for 5 cycles, then IDLE.
4. `estop` asserted mid-FEED:
   - -> FAULT next edge, all drive outputs 0, `fault`=1.
   - `fault_clr` while `estop`=1 -> ignored.
   - `estop`=0 then `fault_clr` -> IDLE.
5. `LATHE_WATCHDOG_EN` defined, FEED with no `limit_end` -> FAULT exactly 50 cycles after FEED entry. Undefined -> FEED held indefinitely.
6. `limit_home`=`limit_end`=1, or `auto_mode`=`man_mode`=1, in any state -> FAULT next edge.
